// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the piso_tx transmitter.
// Holds the FSM state encoding and the bit-counter width rule.
package piso_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Mod-WIDTH up-counter with clear and enable.
// Reports the current count and a terminal flag at WIDTH-1.
module piso_tx_bit_counter
  import piso_tx_pkg::*;
#(
  parameter  int WIDTH = 7,
  localparam int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins, then advance, reloading at the last bit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count    = cnt_q;
  assign terminal = (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load
// and per-bit frame strobes; back-to-back frames have no gap.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             O,
  output logic             O_VALID,
  output logic             O_LAST,
  output logic             BUSY
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             o_q;
  logic             o_d;
  logic             o_valid_q;
  logic             o_valid_d;
  logic             o_last_q;
  logic             o_last_d;

  logic [CW-1:0]    cnt;
  logic             cnt_term;
  logic             in_shift;
  logic             frame_end;
  logic             accept;
  logic             cnt_clr;

  assign in_shift   = (state_q == SHIFT);
  assign frame_end  = in_shift & cnt_term;
  assign LOAD_READY = ~in_shift | cnt_term;
  assign accept     = LOAD_VALID & LOAD_READY;
  assign cnt_clr    = accept | frame_end;

  piso_tx_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk     (CLK),
    .rst     (RESET),
    .clr     (cnt_clr),
    .en      (in_shift),
    .count   (cnt),
    .terminal(cnt_term)
  );

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: a load starts or chains a frame, else drop to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (frame_end && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: first bit leaves with the load, later bits shift out
  always_comb begin
    shreg_d   = shreg_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    if (accept) begin
      o_d       = LSB_FIRST ? DATA[0] : DATA[WIDTH-1];
      shreg_d   = LSB_FIRST ? (DATA >> 1) : (DATA << 1);
      o_valid_d = 1'b1;
      o_last_d  = 1'b0;
    end else if (frame_end) begin
      o_d       = IDLE_LEVEL;
      shreg_d   = '0;
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end else if (in_shift) begin
      o_d       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
      shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
      o_last_d  = (cnt == PRE_LAST);
    end
  end

  // output and shift register flops
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg_q   <= '0;
      o_q       <= IDLE_LEVEL;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
    end
  end

  assign O       = o_q;
  assign O_VALID = o_valid_q;
  assign O_LAST  = o_last_q;
  assign BUSY    = o_valid_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: LSB-first and MSB-first instances share stimulus
// and are checked each cycle against a bit-queue model.
module tb_piso_tx;

  localparam int W = 7;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] DATA = '0;
  logic         LOAD_VALID = 1'b0;

  logic rdy_l, o_l, v_l, last_l, busy_l;
  logic rdy_m, o_m, v_m, last_m, busy_m;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
    .CLK(CLK), .RESET(RESET), .DATA(DATA), .LOAD_VALID(LOAD_VALID),
    .LOAD_READY(rdy_l), .O(o_l), .O_VALID(v_l), .O_LAST(last_l),
    .BUSY(busy_l)
  );

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .CLK(CLK), .RESET(RESET), .DATA(DATA), .LOAD_VALID(LOAD_VALID),
    .LOAD_READY(rdy_m), .O(o_m), .O_VALID(v_m), .O_LAST(last_m),
    .BUSY(busy_m)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of {last,bit} still to appear on O; head is on O now.
  logic [1:0] q_l[$];
  logic [1:0] q_m[$];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_l.delete();
      q_m.delete();
    end else if (q_l.size() > 1) begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end else begin
      if (q_l.size() == 1) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (LOAD_VALID) begin
        for (int i = 0; i < W; i++) begin
          q_l.push_back({i == W - 1, DATA[i]});
          q_m.push_back({i == W - 1, DATA[W-1-i]});
        end
      end
    end
  end

  task automatic cmp(input string t, input logic o, input logic v,
                     input logic l, input logic r, input logic b,
                     input logic [1:0] head, input int n);
    logic has;
    has = (n > 0);
    chk({t, "_o"},     int'(o), int'(has ? head[0] : 1'b0));
    chk({t, "_valid"}, int'(v), int'(has));
    chk({t, "_last"},  int'(l), int'(has ? head[1] : 1'b0));
    chk({t, "_ready"}, int'(r), int'(n <= 1));
    chk({t, "_busy"},  int'(b), int'(has));
  endtask

  // Capture of what each DUT put on the line, for literal checks.
  logic [31:0] seq_l, seq_m;
  logic [W-1:0] rx_l, rx_m;
  int n_l, n_m, lastn_l, lastn_m, run_l, maxrun_l, rdyv_l;

  task automatic clr_caps();
    seq_l = '0; seq_m = '0; rx_l = '0; rx_m = '0;
    n_l = 0; n_m = 0; lastn_l = 0; lastn_m = 0;
    run_l = 0; maxrun_l = 0; rdyv_l = 0;
  endtask

  always @(negedge CLK) begin
    cmp("lsb", o_l, v_l, last_l, rdy_l, busy_l,
        (q_l.size() > 0) ? q_l[0] : 2'b00, q_l.size());
    cmp("msb", o_m, v_m, last_m, rdy_m, busy_m,
        (q_m.size() > 0) ? q_m[0] : 2'b00, q_m.size());
    if (v_l) begin
      seq_l = {seq_l[30:0], o_l};
      rx_l  = {o_l, rx_l[W-1:1]};
      n_l++;
      run_l++;
      if (run_l > maxrun_l) maxrun_l = run_l;
      if (last_l) lastn_l++;
      if (rdy_l) rdyv_l++;
    end else begin
      run_l = 0;
    end
    if (v_m) begin
      seq_m = {seq_m[30:0], o_m};
      rx_m  = {rx_m[W-2:0], o_m};
      n_m++;
      if (last_m) lastn_m++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Offer a word and hold it until an edge with ready high takes it.
  task automatic send(input logic [W-1:0] w, output int waited);
    bit done;
    bit was;
    done = 1'b0;
    waited = 0;
    DATA = w;
    LOAD_VALID = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      was = rdy_l;
      tick(1);
      waited++;
      if (was) done = 1'b1;
    end
    chk("send_accept", int'(done), 1);
  endtask

  task automatic chk_idle(input string t);
    chk({t, "_o_l"}, int'(o_l), 0);
    chk({t, "_v_l"}, int'(v_l), 0);
    chk({t, "_last_l"}, int'(last_l), 0);
    chk({t, "_rdy_l"}, int'(rdy_l), 1);
    chk({t, "_o_m"}, int'(o_m), 0);
    chk({t, "_v_m"}, int'(v_m), 0);
    chk({t, "_rdy_m"}, int'(rdy_m), 1);
  endtask

  initial begin
    int wt;
    clr_caps();
    #2;
    chk_idle("in_reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk_idle("after_reset");
    tick(2);

    // single LSB-first word
    clr_caps();
    send(7'b1011001, wt);
    chk("single_wait", wt, 1);
    LOAD_VALID = 1'b0;
    DATA = 7'h00;
    tick(10);
    chk("single_n", n_l, 7);
    chk("single_seq", int'(seq_l), int'(7'b1001101));
    chk("single_rx", int'(rx_l), int'(7'b1011001));
    chk("single_last", lastn_l, 1);
    chk("single_run", maxrun_l, 7);
    chk("single_msb_seq", int'(seq_m), int'(7'b1011001));

    // MSB-first word
    clr_caps();
    send(7'h55, wt);
    LOAD_VALID = 1'b0;
    tick(10);
    chk("msb_n", n_m, 7);
    chk("msb_seq", int'(seq_m), int'(7'b1010101));
    chk("msb_rx", int'(rx_m), int'(7'h55));
    chk("msb_last", lastn_m, 1);

    // back-to-back words
    clr_caps();
    send(7'h01, wt);
    send(7'h7E, wt);
    chk("b2b_wait", wt, 7);
    LOAD_VALID = 1'b0;
    tick(20);
    chk("b2b_n", n_l, 14);
    chk("b2b_seq", int'(seq_l), int'(14'b10000000111111));
    chk("b2b_run", maxrun_l, 14);
    chk("b2b_last", lastn_l, 2);
    chk("b2b_rdy_in_frame", rdyv_l, 2);
    chk("b2b_rx", int'(rx_l), int'(7'h7E));

    // stall: request raised in frame cycle 3
    clr_caps();
    send(7'h2A, wt);
    LOAD_VALID = 1'b0;
    DATA = 7'h7F;
    tick(2);
    send(7'h11, wt);
    chk("stall_wait", wt, 5);
    LOAD_VALID = 1'b0;
    tick(2);
    DATA = 7'h00;
    tick(15);
    chk("stall_n", n_l, 14);
    chk("stall_seq", int'(seq_l), int'(14'b01010101000100));
    chk("stall_run", maxrun_l, 14);
    chk("stall_rx", int'(rx_l), int'(7'h11));

    // reset aborting a frame
    clr_caps();
    send(7'h7F, wt);
    LOAD_VALID = 1'b0;
    tick(3);
    chk("abort_pre_v", int'(v_l), 1);
    #2;
    RESET = 1'b1;
    #1;
    chk_idle("abort_now");
    @(posedge CLK);
    #1;
    chk_idle("abort_hold");
    RESET = 1'b0;
    clr_caps();
    #1;
    chk_idle("abort_release");
    tick(3);
    chk("abort_no_stale", n_l, 0);
    send(7'h5A, wt);
    LOAD_VALID = 1'b0;
    tick(10);
    chk("abort_n", n_l, 7);
    chk("abort_seq", int'(seq_l), int'(7'b0101101));
    chk("abort_rx_l", int'(rx_l), int'(7'h5A));
    chk("abort_rx_m", int'(rx_m), int'(7'h5A));
    chk("abort_last", lastn_l, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
